// File: rtl/coprocessor_driver_if.sv
// Byte-stream and coprocessor-side signal bundle for coprocessor_driver.
// master = host/memory and coprocessor side, slave = the driver itself.
interface coprocessor_driver_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [1:0]   cmd_size;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic [2:0]   cop_op_code;
    logic [1:0]   cop_matrix_size;
    logic [199:0] cop_pixel_data;
    logic [199:0] cop_kernel_data;
    logic         cop_done;
    logic [199:0] cop_result;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_last;
    logic         done;
    logic         err;

    modport master (
        output cmd_valid, cmd_op, cmd_size, in_valid, in_data, cop_done, cop_result, out_ready,
        input  cmd_ready, in_ready, cop_op_code, cop_matrix_size, cop_pixel_data, cop_kernel_data,
               out_valid, out_data, out_last, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_size, in_valid, in_data, cop_done, cop_result, out_ready,
        output cmd_ready, in_ready, cop_op_code, cop_matrix_size, cop_pixel_data, cop_kernel_data,
               out_valid, out_data, out_last, done, err
    );
endinterface

// File: rtl/coprocessor_driver.sv
// Sequential front end for the combinational convolution coprocessor: loads kernel and
// pixel windows from a byte stream, runs the coprocessor, and streams the result back.
module coprocessor_driver #(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    coprocessor_driver_if.slave  bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_K = 3'd1;
    localparam logic [2:0] ST_LOAD_P = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    localparam logic [2:0] OP_CONV = 3'b111;

    logic [2:0]      state_r;
    logic [1:0]      size_r;
    logic [2:0]      row_r;
    logic [2:0]      col_r;
    logic [WD_W-1:0] wd_r;
    logic [199:0]    kernel_r;
    logic [199:0]    pixel_r;
    logic [199:0]    result_r;
    logic            done_r;
    logic            err_r;

    logic [2:0]      last_idx_s;
    logic [4:0]      elem_s;
    logic [7:0]      bit_s;
    logic            at_last_s;
    logic [2:0]      row_nx_s;
    logic [2:0]      col_nx_s;

    // Element (r,c) lives at byte 5r+c regardless of the active window size.
    assign last_idx_s = {1'b0, size_r} + 3'd1;
    assign elem_s     = {row_r, 2'b00} + {2'b00, row_r} + {2'b00, col_r};
    assign bit_s      = {elem_s, 3'b000};
    assign at_last_s  = (row_r == last_idx_s) && (col_r == last_idx_s);

    // Row-major walk over the N x N window; wraps to (0,0) after the final element.
    always_comb begin
        row_nx_s = row_r;
        col_nx_s = col_r;
        if (at_last_s) begin
            row_nx_s = 3'd0;
            col_nx_s = 3'd0;
        end else if (col_r == last_idx_s) begin
            row_nx_s = row_r + 3'd1;
            col_nx_s = 3'd0;
        end else begin
            col_nx_s = col_r + 3'd1;
        end
    end

    assign bus.cmd_ready       = (state_r == ST_IDLE);
    assign bus.in_ready        = (state_r == ST_LOAD_K) || (state_r == ST_LOAD_P);
    assign bus.out_valid       = (state_r == ST_DRAIN);
    assign bus.out_last        = (state_r == ST_DRAIN) && at_last_s;
    assign bus.out_data        = (state_r == ST_DRAIN) ? result_r[bit_s +: 8] : 8'd0;
    assign bus.cop_op_code     = (state_r == ST_EXEC) ? OP_CONV : 3'b000;
    assign bus.cop_matrix_size = size_r;
    assign bus.cop_kernel_data = kernel_r;
    assign bus.cop_pixel_data  = pixel_r;
    assign bus.done            = done_r;
    assign bus.err             = err_r;

    // Transaction sequencer: command accept, window loads, watchdogged execution, drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            size_r   <= 2'b00;
            row_r    <= 3'd0;
            col_r    <= 3'd0;
            wd_r     <= '0;
            kernel_r <= '0;
            pixel_r  <= '0;
            result_r <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        size_r   <= bus.cmd_size;
                        kernel_r <= '0;
                        pixel_r  <= '0;
                        row_r    <= 3'd0;
                        col_r    <= 3'd0;
                        if (bus.cmd_op == OP_CONV) begin
                            state_r <= ST_LOAD_K;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_LOAD_K: begin
                    if (bus.in_valid) begin
                        kernel_r[bit_s +: 8] <= bus.in_data;
                        row_r <= row_nx_s;
                        col_r <= col_nx_s;
                        if (at_last_s) begin
                            state_r <= ST_LOAD_P;
                        end
                    end
                end
                ST_LOAD_P: begin
                    if (bus.in_valid) begin
                        pixel_r[bit_s +: 8] <= bus.in_data;
                        row_r <= row_nx_s;
                        col_r <= col_nx_s;
                        if (at_last_s) begin
                            wd_r    <= '0;
                            state_r <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    // The watchdog counts completed EXEC cycles; the TIMEOUT-th idle one aborts.
                    if (bus.cop_done) begin
                        result_r <= bus.cop_result;
                        state_r  <= ST_DRAIN;
                    end else if (wd_r == WD_W'(TIMEOUT - 1)) begin
                        err_r   <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (bus.out_ready) begin
                        row_r <= row_nx_s;
                        col_r <= col_nx_s;
                        if (at_last_s) begin
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_coprocessor_driver.sv
// Self-checking bench for coprocessor_driver: table of transactions plus random ones,
// checked against a byte-list model of the 5x5-stride packing, and a reset-abort sequence.
module tb_coprocessor_driver;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    coprocessor_driver_if bus();

    coprocessor_driver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [1:0] size;
        logic [2:0] op;
        int         lat;
        bit         gaps;
        bit         stalls;
        int         mode;
        bit         exp_err;
        int         exp_exec;
    } vec_t;

    vec_t         vecs[16];
    logic [199:0] k22;
    logic [199:0] p22;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int n, nn, idx, ecyc, j, budget, t0;
        logic [199:0] ek, ep, res;
        logic [7:0]   strm[50];
        logic [7:0]   rb[25];
        logic         fire;
        n  = int'(v.size) + 2;
        nn = n * n;
        ek = '0;
        ep = '0;
        res = '0;
        for (int i = 0; i < 25; i++) res[8*i +: 8] = (v.mode == 2) ? 8'(i) : 8'($urandom);
        for (int i = 0; i < nn; i++) begin
            int r, c, k;
            r = i / n;
            c = i % n;
            k = 5 * r + c;
            strm[i]      = (v.mode == 1) ? 8'(i + 1) : 8'($urandom);
            strm[nn + i] = (v.mode == 1) ? 8'(10 * (i + 1)) : 8'($urandom);
            ek[8*k +: 8] = strm[i];
            ep[8*k +: 8] = strm[nn + i];
            rb[i]        = res[8*k +: 8];
        end

        @(negedge clk);
        chk("cmd_ready_idle", 200'(bus.cmd_ready), 200'(1));
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_size  = v.size;
        t0 = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (v.exp_err) begin
            chk("err_illegal_op", 200'(bus.err), 200'(1));
            chk("cmd_ready_after_err", 200'(bus.cmd_ready), 200'(1));
            chk("in_ready_after_err", 200'(bus.in_ready), 200'(0));
            @(negedge clk);
            chk("err_single_cycle", 200'(bus.err), 200'(0));
            return;
        end
        chk("cmd_ready_busy", 200'(bus.cmd_ready), 200'(0));

        idx = 0;
        budget = 0;
        while (idx < 2 * nn && budget < 400) begin
            chk("in_ready_load", 200'(bus.in_ready), 200'(1));
            chk("opcode_load", 200'(bus.cop_op_code), 200'(0));
            bus.in_valid = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = strm[idx];
            fire = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (fire) idx++;
            budget++;
        end
        bus.in_valid = 1'b0;
        if (idx < 2 * nn) chk("load_budget", 200'(idx), 200'(2 * nn));

        chk("opcode_exec", 200'(bus.cop_op_code), 200'(3'b111));
        chk("matrix_size", 200'(bus.cop_matrix_size), 200'(v.size));
        chk("in_ready_exec", 200'(bus.in_ready), 200'(0));
        if (v.mode == 1) begin
            chk("kernel_bus_2x2", bus.cop_kernel_data, k22);
            chk("pixel_bus_2x2", bus.cop_pixel_data, p22);
        end
        ecyc = 0;
        while (bus.cop_op_code == 3'b111 && ecyc < 40) begin
            chk("kernel_bus", bus.cop_kernel_data, ek);
            chk("pixel_bus", bus.cop_pixel_data, ep);
            bus.cop_done   = (ecyc >= v.lat);
            bus.cop_result = res;
            @(negedge clk);
            ecyc++;
        end
        bus.cop_done   = 1'b0;
        bus.cop_result = '1;
        chk("exec_cycles", 200'(ecyc), 200'(v.exp_exec));

        if (v.lat >= 16) begin
            chk("err_timeout", 200'(bus.err), 200'(1));
            chk("out_valid_timeout", 200'(bus.out_valid), 200'(0));
            chk("cmd_ready_timeout", 200'(bus.cmd_ready), 200'(1));
            @(negedge clk);
            chk("err_timeout_single", 200'(bus.err), 200'(0));
            chk("out_valid_after_timeout", 200'(bus.out_valid), 200'(0));
            return;
        end

        j = 0;
        budget = 0;
        while (j < nn && budget < 400) begin
            chk("out_valid", 200'(bus.out_valid), 200'(1));
            chk("out_data", 200'(bus.out_data), 200'(rb[j]));
            chk("out_last", 200'(bus.out_last), 200'(j == nn - 1));
            chk("done_early", 200'(bus.done), 200'(0));
            bus.out_ready = v.stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            fire = bus.out_ready && bus.out_valid;
            @(negedge clk);
            if (fire) j++;
            budget++;
        end
        bus.out_ready = 1'b0;
        if (j < nn) chk("drain_budget", 200'(j), 200'(nn));
        chk("done_pulse", 200'(bus.done), 200'(1));
        chk("out_valid_after", 200'(bus.out_valid), 200'(0));
        chk("cmd_ready_on_done", 200'(bus.cmd_ready), 200'(1));
        chk("err_on_done", 200'(bus.err), 200'(0));
        if (!v.gaps && !v.stalls && v.lat == 0)
            chk("total_cycles", 200'(cyc - t0), 200'(3 * nn + 2));
        @(negedge clk);
        chk("done_single_cycle", 200'(bus.done), 200'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        cyc = 0;
        checks = 0;
        errors = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'b000;
        bus.cmd_size = 2'b00;
        bus.in_valid = 1'b0;
        bus.in_data = 8'd0;
        bus.cop_done = 1'b0;
        bus.cop_result = '0;
        bus.out_ready = 1'b0;

        k22 = '0;
        k22[7:0] = 8'd1;   k22[15:8] = 8'd2;   k22[47:40] = 8'd3;  k22[55:48] = 8'd4;
        p22 = '0;
        p22[7:0] = 8'd10;  p22[15:8] = 8'd20;  p22[47:40] = 8'd30; p22[55:48] = 8'd40;

        vecs[0] = '{2'd0, 3'b111, 0,    1'b0, 1'b0, 1, 1'b0, 1};
        vecs[1] = '{2'd3, 3'b111, 0,    1'b0, 1'b0, 2, 1'b0, 1};
        vecs[2] = '{2'd1, 3'b111, 2,    1'b1, 1'b1, 0, 1'b0, 3};
        vecs[3] = '{2'd0, 3'b010, 0,    1'b0, 1'b0, 0, 1'b1, 0};
        vecs[4] = '{2'd2, 3'b111, 1000, 1'b0, 1'b0, 0, 1'b0, 16};
        vecs[5] = '{2'd2, 3'b111, 15,   1'b0, 1'b0, 0, 1'b0, 16};
        vecs[6] = '{2'd0, 3'b111, 0,    1'b0, 1'b0, 0, 1'b0, 1};
        for (int i = 7; i < 16; i++) begin
            vecs[i].size   = 2'($urandom_range(0, 3));
            vecs[i].op     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 6)) : 3'b111;
            vecs[i].lat    = $urandom_range(0, 3);
            vecs[i].gaps   = 1'($urandom_range(0, 1));
            vecs[i].stalls = 1'($urandom_range(0, 1));
            vecs[i].mode   = 0;
            vecs[i].exp_err  = (vecs[i].op != 3'b111);
            vecs[i].exp_exec = vecs[i].lat + 1;
        end

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 200'(bus.in_ready), 200'(0));
        chk("rst_opcode", 200'(bus.cop_op_code), 200'(0));
        chk("rst_kernel", bus.cop_kernel_data, 200'(0));
        chk("rst_out_valid", 200'(bus.out_valid), 200'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 200'(bus.cmd_ready), 200'(1));
        chk("rst_done_err", 200'({bus.done, bus.err}), 200'(0));

        for (int i = 0; i < 16; i++) run_txn(vecs[i]);

        // Reset partway through the pixel load of a 4x4 transaction.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b111;
        bus.cmd_size  = 2'd2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hAA;
        repeat (21) @(negedge clk);
        chk("midload_size", 200'(bus.cop_matrix_size), 200'(2'd2));
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 200'(bus.in_ready), 200'(0));
        chk("abort_opcode", 200'(bus.cop_op_code), 200'(0));
        chk("abort_size", 200'(bus.cop_matrix_size), 200'(0));
        chk("abort_kernel", bus.cop_kernel_data, 200'(0));
        chk("abort_pixel", bus.cop_pixel_data, 200'(0));
        chk("abort_outputs", 200'({bus.out_valid, bus.out_last, bus.done, bus.err}), 200'(0));
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_cmd_ready", 200'(bus.cmd_ready), 200'(1));
        chk("abort_no_pulse", 200'({bus.done, bus.err}), 200'(0));
        run_txn('{2'd0, 3'b111, 0, 1'b0, 1'b0, 0, 1'b0, 1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
